// File: rtl/snn_img_host_pkg.sv
// snn_img_host_pkg: state encoding, image geometry and ASCII reply decoding shared by the SNN image host
package snn_pkg;
  localparam int NUM_PIXELS = 784;
  localparam int NUM_BYTES_DEF = 98;
  localparam int ADDR_W = $clog2(NUM_PIXELS);
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  typedef enum logic [2:0] {IDLE, FETCH, SEND, WAIT_TX, WAIT_RESP, DONE} state_t;
  function automatic logic is_digit(input logic [7:0] b);
    return b[7:4] == ASCII_ZERO[7:4] && b[3:0] <= 4'd9;
  endfunction
endpackage

// File: rtl/snn_img_host_if.sv
// snn_img_host_if: image memory read port plus uart_tx/uart_rx handshake
//   master (host): drives img_addr, tx_data, trmt; samples img_q, tx_rdy, rx_rdy, rx_data
//   slave (memory/uart side): the mirror image
interface snn_img_host_if;
  import snn_pkg::*;
  logic [ADDR_W-1:0] img_addr;
  logic img_q;
  logic [7:0] tx_data;
  logic trmt;
  logic tx_rdy;
  logic rx_rdy;
  logic [7:0] rx_data;
  modport master(output img_addr, tx_data, trmt, input img_q, tx_rdy, rx_rdy, rx_data);
  modport slave(input img_addr, tx_data, trmt, output img_q, tx_rdy, rx_rdy, rx_data);
endinterface

// File: rtl/snn_img_host_byte_packer.sv
// snn_byte_packer: reads 8 consecutive pixels from a 1-cycle-latency memory and packs them LSB first
//   go/base_addr: start a byte at base_addr; img_addr/img_q: memory port
//   byte_vld/byte_data: one-cycle strobe with the packed byte (bit j = pixel base_addr+j)
module snn_byte_packer
  import snn_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              img_q,
  output logic [ADDR_W-1:0] img_addr,
  output logic              byte_vld,
  output logic [7:0]        byte_data
);
  logic r_run, r_cap;
  logic [2:0] r_bit_cnt, r_cap_idx;
  logic [6:0] r_shift;
  logic [ADDR_W-1:0] r_addr;
  logic w_more;
  assign w_more = r_run & (r_bit_cnt != 3'd7);
  // address issue and capture run one cycle apart: r_cap_idx names the bit whose data is on img_q now
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_run <= 1'b0;
      r_cap <= 1'b0;
      r_bit_cnt <= '0;
      r_cap_idx <= '0;
      r_shift <= '0;
      r_addr <= '0;
    end else begin
      r_run <= go | w_more;
      r_bit_cnt <= go ? 3'd0 : r_bit_cnt + {2'b00, r_run};
      r_addr <= go ? base_addr : r_addr + {{(ADDR_W-1){1'b0}}, w_more};
      r_cap <= r_run;
      r_cap_idx <= r_bit_cnt;
      if (r_cap && r_cap_idx != 3'd7) r_shift[r_cap_idx] <= img_q;
    end
  assign img_addr = r_addr;
  assign byte_vld = r_cap & (r_cap_idx == 3'd7);
  assign byte_data = {img_q, r_shift};
endmodule

// File: rtl/snn_img_host.sv
// snn_img_host: streams a 784-pixel 1-bit image as packed bytes over uart_tx and decodes the ASCII digit reply
//   clk/rst_n: clock, async active-low reset; start: one-cycle request
//   bus (master): image memory and uart handshakes
//   busy/done: transaction status; digit/err/timeout: outcome of the last transaction
module snn_img_host
  import snn_pkg::*;
#(
  parameter int NUM_BYTES = NUM_BYTES_DEF,
  parameter int TIMEOUT_CYC = 1048576,
  parameter int TO_W = 21
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  snn_img_host_if.master       bus,
  output logic                 busy,
  output logic                 done,
  output logic [3:0]           digit,
  output logic                 err,
  output logic                 timeout
);
  state_t r_state, w_nxt;
  logic [6:0] r_byte_cnt;
  logic [TO_W-1:0] r_to_cnt, w_to_nxt;
  logic [7:0] r_tx_data, w_byte;
  logic [3:0] r_digit;
  logic r_err, r_timeout, r_skip;
  logic w_go, w_trmt, w_last, w_to_hit, w_vld;
  logic [ADDR_W-1:0] w_base;
  assign w_last = r_byte_cnt == 7'(NUM_BYTES - 1);
  assign w_to_nxt = r_to_cnt + TO_W'(1);
  assign w_to_hit = w_to_nxt == TO_W'(TIMEOUT_CYC);
  assign w_base = r_state == IDLE ? '0 : {r_byte_cnt + 7'd1, 3'b000};
  snn_byte_packer u_packer (
    .clk(clk),
    .rst_n(rst_n),
    .go(w_go),
    .base_addr(w_base),
    .img_q(bus.img_q),
    .img_addr(bus.img_addr),
    .byte_vld(w_vld),
    .byte_data(w_byte)
  );
  // r_skip masks the cycle right after trmt, before uart_tx has dropped tx_rdy
  always_comb begin
    w_nxt = r_state;
    w_go = 1'b0;
    w_trmt = 1'b0;
    case (r_state)
      IDLE: begin
        w_go = start;
        w_nxt = start ? FETCH : IDLE;
      end
      FETCH: w_nxt = w_vld ? SEND : FETCH;
      SEND: begin
        w_trmt = bus.tx_rdy;
        w_nxt = bus.tx_rdy ? WAIT_TX : SEND;
      end
      WAIT_TX: if (!r_skip && bus.tx_rdy) begin
        w_go = !w_last;
        w_nxt = w_last ? WAIT_RESP : FETCH;
      end
      WAIT_RESP: w_nxt = (bus.rx_rdy || w_to_hit) ? DONE : WAIT_RESP;
      DONE: w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_byte_cnt <= '0;
      r_to_cnt <= '0;
      r_tx_data <= '0;
      r_digit <= '0;
      r_err <= 1'b0;
      r_timeout <= 1'b0;
      r_skip <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_skip <= w_trmt;
      if (r_state == IDLE && start) begin
        r_err <= 1'b0;
        r_timeout <= 1'b0;
        r_byte_cnt <= '0;
      end
      if (r_state == FETCH && w_vld) r_tx_data <= w_byte;
      if (r_state == WAIT_TX && w_nxt != WAIT_TX) begin
        r_byte_cnt <= r_byte_cnt + {6'd0, !w_last};
        r_to_cnt <= '0;
      end
      // a reply landing in the same cycle the window expires still counts as a reply
      if (r_state == WAIT_RESP) begin
        r_to_cnt <= w_to_nxt;
        if (bus.rx_rdy) begin
          r_err <= !is_digit(bus.rx_data);
          if (is_digit(bus.rx_data)) r_digit <= bus.rx_data[3:0];
        end else if (w_to_hit) r_timeout <= 1'b1;
      end
    end
  assign bus.trmt = w_trmt;
  assign bus.tx_data = r_tx_data;
  assign busy = r_state != IDLE && r_state != DONE;
  assign done = r_state == DONE;
  assign digit = r_digit;
  assign err = r_err;
  assign timeout = r_timeout;
endmodule

// File: tb/tb_snn_img_host.sv
// tb_snn_img_host: randomized scoreboard bench for snn_img_host with memory and uart models
module tb_snn_img_host;
  localparam int NB = 98;
  localparam int TO = 100;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done, err, timeout;
  logic [3:0] digit;
  snn_img_host_if bus();
  snn_img_host #(.NUM_BYTES(NB), .TIMEOUT_CYC(TO), .TO_W(21)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
    .busy(busy), .done(done), .digit(digit), .err(err), .timeout(timeout)
  );
  always #5 clk = ~clk;
  typedef struct packed {logic [3:0] digit; logic err; logic to;} res_t;
  logic [7:0] exp_bytes[$];
  res_t exp_res[$];
  bit mem[784];
  int checks = 0, errors = 0, cyc = 0;
  int hold = 0, tx_cnt = 0, rise_cyc = -1, done_cnt = 0, done_cyc = -1;
  logic [3:0] m_digit = 4'd0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  // synchronous image memory: data for the address seen in one cycle appears in the next
  initial begin
    int a;
    bus.img_q = 1'b0;
    forever begin
      @(negedge clk);
      a = int'(bus.img_addr);
      @(posedge clk);
      #1 bus.img_q = (a < 784) ? mem[a] : 1'b0;
    end
  end
  // uart_tx model: tx_rdy low for 'hold' cycles starting the cycle after trmt
  initial begin
    bus.tx_rdy = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && bus.trmt) begin
        tx_cnt++;
        if (hold == 0) begin
          if (tx_cnt == NB) rise_cyc = cyc + 2;
        end else begin
          @(posedge clk);
          #1 bus.tx_rdy = 1'b0;
          repeat (hold) @(posedge clk);
          #1 bus.tx_rdy = 1'b1;
          if (tx_cnt == NB) rise_cyc = cyc;
        end
      end
    end
  end
  // monitor: pops expected bytes on trmt and expected outcomes on done
  initial begin
    res_t r;
    forever begin
      @(negedge clk);
      if (rst_n && bus.trmt) begin
        chk("trmt_while_tx_busy", bus.tx_rdy, 1);
        if (exp_bytes.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_trmt: got byte %0h expected no further bytes", bus.tx_data);
        end else chk("tx_byte", bus.tx_data, exp_bytes.pop_front());
      end
      if (rst_n && done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("busy_at_done", busy, 0);
        chk("bytes_missing", exp_bytes.size(), 0);
        if (exp_res.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done expected none");
        end else begin
          r = exp_res.pop_front();
          chk("digit", digit, r.digit);
          chk("err", err, r.err);
          chk("timeout", timeout, r.to);
        end
      end
    end
  end
  task automatic push_image();
    logic [7:0] b;
    for (int k = 0; k < NB; k++) begin
      b = '0;
      for (int j = 0; j < 8; j++) b[j] = mem[8*k+j];
      exp_bytes.push_back(b);
    end
  endtask
  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic run_txn(input int h, input bit has_rep, input logic [7:0] rep, input int k, input bit inject);
    res_t r;
    int d0, n, exp_done;
    hold = h;
    tx_cnt = 0;
    rise_cyc = -1;
    d0 = done_cnt;
    push_image();
    if (has_rep && rep[7:4] == 4'h3 && rep[3:0] <= 4'd9) m_digit = rep[3:0];
    r.digit = m_digit;
    r.err = has_rep && !(rep[7:4] == 4'h3 && rep[3:0] <= 4'd9);
    r.to = !has_rep;
    exp_res.push_back(r);
    pulse_start();
    chk("busy_after_start", busy, 1);
    chk("err_cleared", err, 0);
    chk("timeout_cleared", timeout, 0);
    if (inject) begin
      n = 0;
      while (tx_cnt < 40 && n < 20000) begin
        @(posedge clk);
        #1 n++;
      end
      bus.rx_data = 8'h35;
      bus.rx_rdy = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1 bus.rx_rdy = 1'b0;
      start = 1'b0;
      repeat (7) @(posedge clk);
      pulse_start();
      pulse_start();
    end
    n = 0;
    while (rise_cyc < 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (rise_cyc < 0) begin
      checks++;
      errors++;
      $display("FAIL last_byte_wait: got %0d bytes expected %0d", tx_cnt, NB);
      return;
    end
    if (has_rep) begin
      while (cyc < rise_cyc + k) begin
        @(posedge clk);
        #1;
      end
      bus.rx_data = rep;
      bus.rx_rdy = 1'b1;
      @(posedge clk);
      #1 bus.rx_rdy = 1'b0;
    end
    exp_done = rise_cyc + (has_rep ? k : TO) + 1;
    n = 0;
    while (done_cnt == d0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", done_cnt - d0, 1);
    chk("done_cycle", done_cyc, exp_done);
    repeat (3) @(negedge clk);
    chk("single_done", done_cnt - d0, 1);
    chk("idle_not_busy", busy, 0);
  endtask
  initial begin
    int d0, n;
    bus.rx_rdy = 1'b0;
    bus.rx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_digit", digit, 0);
    chk("rst_err", err, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_trmt", bus.trmt, 0);
    chk("rst_img_addr", bus.img_addr, 0);
    chk("rst_tx_data", bus.tx_data, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    // walking one at pixel 9, instant uart, reply '7'
    for (int i = 0; i < 784; i++) mem[i] = (i == 9);
    run_txn(0, 1'b1, 8'h37, 5, 1'b0);
    // alternating pixels, slow uart, non-digit reply
    for (int i = 0; i < 784; i++) mem[i] = i[0];
    run_txn(20, 1'b1, 8'h41, 10, 1'b0);
    // random image, no reply: timeout
    for (int i = 0; i < 784; i++) mem[i] = 1'($urandom_range(0, 1));
    run_txn(3, 1'b0, 8'h00, 0, 1'b0);
    // reply in the last cycle of the window
    for (int i = 0; i < 784; i++) mem[i] = 1'($urandom_range(0, 1));
    run_txn(1, 1'b1, 8'h39, TO, 1'b0);
    // stray rx and extra starts mid-stream
    for (int i = 0; i < 784; i++) mem[i] = 1'($urandom_range(0, 1));
    run_txn(2, 1'b1, 8'h33, 7, 1'b1);
    // reset during byte 50
    for (int i = 0; i < 784; i++) mem[i] = 1'($urandom_range(0, 1));
    hold = 5;
    tx_cnt = 0;
    rise_cyc = -1;
    d0 = done_cnt;
    push_image();
    pulse_start();
    n = 0;
    while (tx_cnt < 50 && n < 20000) begin
      @(posedge clk);
      #1 n++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_trmt", bus.trmt, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_digit", digit, 0);
    chk("mid_rst_img_addr", bus.img_addr, 0);
    chk("mid_rst_tx_data", bus.tx_data, 0);
    exp_bytes.delete();
    m_digit = 4'd0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("no_done_on_reset", done_cnt - d0, 0);
    // fresh images after reset and random replies
    for (int t = 0; t < 3; t++) begin
      logic [7:0] rep;
      for (int i = 0; i < 784; i++) mem[i] = 1'($urandom_range(0, 1));
      rep = $urandom_range(0, 1) ? 8'($urandom_range(8'h30, 8'h39)) : 8'($urandom_range(0, 255));
      run_txn(int'($urandom_range(0, 4)), 1'b1, rep, int'($urandom_range(1, TO)), 1'b0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/snn_img_host.md
Name: snn_img_host

Overview:
- Host-side counterpart of the SNN digit-classifier UART protocol.
- Reads a 784-pixel 1-bit image from a synchronous image memory and packs it into 98 bytes, LSB first: byte k bit j = pixel 8k+j.
- Sends the bytes through a uart_tx instance, then waits for the classifier's single ASCII reply byte and reports the decoded digit.
- Used as an on-board self-test driver and as the bench-side model for end-to-end SNN verification.

Parameters:
- NUM_BYTES, 98, bytes per image; pixel count = 8*NUM_BYTES.
- TIMEOUT_CYC, 1048576, max clk cycles allowed between the last byte's tx completion and reply rx_rdy.
- TO_W, 21, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse that begins one image transaction
- img_addr  out  10  pixel address to image memory
- img_q  in  1  pixel data, valid the cycle after img_addr is presented
- tx_data  out  8  byte to uart_tx
- trmt  out  1  one-cycle pulse launching tx_data
- tx_rdy  in  1  uart_tx idle; low from the cycle after trmt until the byte's stop bit completes
- rx_rdy  in  1  uart_rx byte-valid pulse
- rx_data  in  8  received byte
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse at end of transaction (good reply, bad reply, or timeout)
- digit  out  4  last valid decoded digit
- err  out  1  last reply was outside 0x30..0x39
- timeout  out  1  last transaction timed out

Behaviour:
- Reset values: img_addr=0, tx_data=0, trmt=0, busy=0, done=0, digit=0, err=0, timeout=0; state=IDLE; byte and bit counters cleared.
- Reset mid-transaction aborts immediately: trmt drops, state returns to IDLE, no done pulse.
- IDLE: on start go to FETCH. Clear err and timeout. Zero the byte counter, bit counter and address. start is ignored in every state other than IDLE.
- FETCH: present img_addr = 8*byte_cnt + bit_cnt. Capture img_q one cycle later into shift bit bit_cnt (pipelined: a new address every cycle). 8 captured bits complete the byte, 9 cycles per byte max. Then go to SEND.
- SEND: wait for tx_rdy=1. Drive tx_data=packed byte and pulse trmt for exactly one cycle. Go to WAIT_TX.
- WAIT_TX: skip one cycle, then wait for tx_rdy=1.
  - If byte_cnt==NUM_BYTES-1: go to WAIT_RESP and clear the timeout counter.
  - Else increment byte_cnt and go to FETCH.
- trmt is never asserted while tx_rdy=0.
- rx_rdy pulses in FETCH, SEND or WAIT_TX are discarded.
- WAIT_RESP: the timeout counter increments each cycle.
  - On rx_rdy, if rx_data[7:4]==4'h3 and rx_data[3:0]<=9: digit<=rx_data[3:0], err<=0.
  - On rx_rdy with any other byte: err<=1 and digit holds its previous value.
  - Either rx_rdy case goes to DONE.
  - If the counter reaches TIMEOUT_CYC with no rx_rdy: timeout<=1, go to DONE.
  - rx_rdy in the same cycle the count hits TIMEOUT_CYC: rx_rdy wins, no timeout.
- DONE: done=1 for one cycle, busy falls in the same cycle, go to IDLE.
- Address arithmetic: img_addr max 783 (0x30F). Counters do not wrap within a transaction; byte_cnt is 7 bits.
- Latency per image: start to first trmt ≤ 11 cycles. Total ≈ 98*(9 + UART byte time) + reply time.

Decomposition:
- snn_pkg holds the state enum (IDLE, FETCH, SEND, WAIT_TX, WAIT_RESP, DONE) and the constants NUM_PIXELS=784, NUM_BYTES_DEF=98, ASCII_ZERO=8'h30. The snn top's state machine shares the same pixel constants.
- One sub-module, snn_byte_packer: owns bit_cnt, address generation for one byte, and the 1-cycle memory pipeline. It takes go/base_addr and returns byte_vld/byte_data.

Test Plan:
- Walking-one image (only pixel 9 =1), bench uart model instant-ready → byte1=0x02, all other bytes 0x00, exactly 98 trmt pulses; reply 0x37 → digit=7, err=0, one done pulse.
- Image with pixel i = i[0] → every byte 0xAA; tx_rdy held low 20 cycles after each trmt → no trmt while tx_rdy=0 and byte order preserved.
- Reply 0x41 after last byte → err=1, digit keeps previous 7, done pulse; next start clears err.
- TIMEOUT_CYC=100, no reply → timeout=1 and done exactly 100 cycles after the last tx_rdy rise; reply arriving at cycle 100 → digit valid, timeout=0.
- rx_rdy with 0x35 injected during byte 40, then reply 0x33 → only 0x33 honoured, digit=3; start pulses while busy ignored (single 98-byte stream).
- rst_n asserted during byte 50 → trmt=0 and all outputs at reset values next cycle; new start sends byte0 from pixel 0.
